// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// States, op codes, default latencies and the counter width.
package muldiv_pkg;

    localparam int CNT_W        = 6;
    localparam int MULT_LAT_DEF = 33;
    localparam int DIV_LAT_DEF  = 33;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_COMMIT
    } state_e;

endpackage

// File: rtl/muldiv_cycle_counter.sv
// Loadable down-counter that times the fixed unit latency.
// Load wins over decrement; it never wraps below zero.
module muldiv_cycle_counter
    import muldiv_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load, else saturating decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/muldiv_seq.sv
// Multiply/divide sequencer owning the architectural HI/LO registers.
// Optional macro MULDIV_DIV0_TRAP_EN: divide-by-zero skips the divider.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_op,
    output logic        req_ready,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        mult_ctrl,
    output logic        div_ctrl,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

    state_e      state_q;
    state_e      state_d;
    logic        op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic             accept;
    logic             trap_now;
    logic             skip_wr;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;

    assign accept   = req_valid && (state_q == ST_IDLE);
    assign load_val = (op_q == OP_DIV) ? DIV_LOAD : MULT_LOAD;

`ifdef MULDIV_DIV0_TRAP_EN
    logic dz_q;

    assign trap_now = (req_op == OP_DIV) && (rt_val == '0);
    assign skip_wr  = dz_q;
    assign div_zero = (state_q == ST_COMMIT) && dz_q;

    // Remember that the pending commit is a trapped divide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dz_q <= 1'b0;
        end else if (accept) begin
            dz_q <= trap_now;
        end
    end
`else
    assign trap_now = 1'b0;
    assign skip_wr  = 1'b0;
    assign div_zero = 1'b0;
`endif

    muldiv_cycle_counter u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (state_q == ST_START),
        .load_val (load_val),
        .dec      (state_q == ST_WAIT),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    // Next-state logic; WAIT leaves on the edge where the count hits 0.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = trap_now ? ST_COMMIT : ST_START;
                end
            end
            ST_START: begin
                state_d = (load_val == '0) ? ST_COMMIT : ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_zero || (cnt == CNT_W'(1))) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand and op latch, held until the next acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q <= OP_MULT;
            a_q  <= '0;
            b_q  <= '0;
        end else if (accept) begin
            op_q <= req_op;
            a_q  <= rs_val;
            b_q  <= rt_val;
        end
    end

    // HI/LO: unit result at commit, direct writes only when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state_q == ST_COMMIT) begin
            if (!skip_wr) begin
                hi_q <= (op_q == OP_DIV) ? div_hi : mult_hi;
                lo_q <= (op_q == OP_DIV) ? div_lo : mult_lo;
            end
        end else if (state_q == ST_IDLE) begin
            if (hi_we) begin
                hi_q <= wdata;
            end
            if (lo_we) begin
                lo_q <= wdata;
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE) && !reset;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_COMMIT);
    assign mult_ctrl = (state_q == ST_START) && (op_q == OP_MULT);
    assign div_ctrl  = (state_q == ST_START) && (op_q == OP_DIV);
    assign op_a      = a_q;
    assign op_b      = b_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule
